div_seq: RTL and testbench

Sequential signed divider, the inverse operation of the team's combinational multiplier. It takes a 2*WIDTH-bit two's-complement dividend (multiplier product width) and a WIDTH-bit two's-complement divisor, and returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder. It is a restoring shift-subtract core with a start/busy/done handshake and sits beside the multiplier in the arithmetic unit.

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_if.sv | 41 ++++
 rtl/div_step.sv | 38 +++
 rtl/div_seq.sv | 180 ++++++++++++++++++
 tb/tb_div_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared types, sizes and helpers for the sequential signed divider.
//
// Contents:
//   DIV_WIDTH    default divisor/remainder width (dividend/quotient are 2x)
//   DIV_ITER     number of restoring iterations (one per quotient bit)
//   CNT_W        width of the iteration counter
//   MAG_W        width of internal magnitudes; one bit wider than the dividend
//                so that the most negative dividend has a representable |value|
//   div_state_t  control FSM states
//   abs_mag()    two's-complement absolute value at MAG_W bits
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 6;
    localparam int DIV_ITER  = 2 * DIV_WIDTH;
    localparam int CNT_W     = $clog2(DIV_ITER + 1);
    localparam int MAG_W     = DIV_ITER + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Operand must already be sign-extended to MAG_W bits.
    function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] v);
        abs_mag = v[MAG_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if -- request/result bundle between a client and div_seq.
//
// Signals:
//   start        request pulse, honoured only while the divider is idle
//   dividend     signed, 2*WIDTH bits
//   divisor      signed, WIDTH bits
//   busy         divider is working (CALC or FIX)
//   done         one-cycle pulse; results valid from this cycle on
//   quotient     signed, 2*WIDTH bits, truncated toward zero
//   remainder    signed, WIDTH bits, sign follows the dividend
//   div_by_zero  flags a result produced with a zero divisor
//
// Modports: master = client side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step -- one combinational restoring shift-subtract step on magnitudes.
//
// Ports:
//   rem_in   partial remainder before this step (always < div_mag)
//   bit_in   next dividend bit, shifted into the remainder LSB
//   div_mag  |divisor|
//   rem_out  partial remainder after this step
//   q_bit    quotient bit produced by this step
//
// RW is one bit wider than the divisor so that |most negative divisor| fits.
// -----------------------------------------------------------------------------
module div_step #(
    parameter int RW = 7
) (
    input  logic [RW-1:0] rem_in,
    input  logic          bit_in,
    input  logic [RW-1:0] div_mag,
    output logic [RW-1:0] rem_out,
    output logic          q_bit
);

    logic [RW:0] shifted;
    logic [RW:0] diff;
    logic        fits;

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, div_mag};
        fits    = (shifted >= {1'b0, div_mag});
        q_bit   = fits;
        // Either result is below div_mag here, so dropping the top bit is safe.
        rem_out = fits ? RW'(diff) : RW'(shifted);
    end

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- sequential signed divider (restoring, one quotient bit per cycle).
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset; aborts any operation in flight
//   bus   div_if.slave: start/dividend/divisor in, busy/done/results out
//
// Flow: IDLE captures magnitudes and sign bits on start, CALC runs 2*WIDTH
// restoring steps, FIX applies signs and registers the results, DONE pulses
// done for one cycle. Results hold until the next operation or reset.
// A zero divisor yields quotient = all ones, remainder = dividend[WIDTH-1:0]
// and div_by_zero = 1.
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, a zero dividend or divisor skips CALC and
//                     goes straight to FIX (same result values, 2-cycle latency).
//
// WIDTH must not exceed div_pkg::DIV_WIDTH (magnitudes are formed at MAG_W).
// -----------------------------------------------------------------------------
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);

    localparam int QW   = 2 * WIDTH;
    localparam int RW   = WIDTH + 1;
    localparam int ITER = 2 * WIDTH;
    localparam int CW   = $clog2(ITER + 1);

    div_state_t     state;
    div_state_t     state_nxt;

    logic [CW-1:0]    cnt;
    logic [QW-1:0]    dq;        // dividend bits shift out the top, quotient bits in the bottom
    logic [RW-1:0]    prem;      // partial remainder magnitude
    logic [RW-1:0]    dvs_mag;
    logic             sign_dvd;
    logic             sign_dvs;
    logic             dvs_zero;
    logic [WIDTH-1:0] dvd_lo;    // returned as the remainder on divide-by-zero

    logic [MAG_W-1:0] dvd_abs;
    logic [MAG_W-1:0] dvs_abs;
    logic             early;
    logic [RW-1:0]    step_rem;
    logic             step_q;

    logic             busy;
    logic             done;
    logic [QW-1:0]    quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Operand magnitudes, formed one bit wider than the operands.
    always_comb begin
        dvd_abs = abs_mag({{(MAG_W-QW){bus.dividend[QW-1]}}, bus.dividend});
        dvs_abs = abs_mag({{(MAG_W-WIDTH){bus.divisor[WIDTH-1]}}, bus.divisor});
    end

`ifdef DIV_EARLY_OUT_EN
    assign early = (bus.dividend == '0) || (bus.divisor == '0);
`else
    assign early = 1'b0;
`endif

    div_step #(
        .RW (RW)
    ) u_step (
        .rem_in  (prem),
        .bit_in  (dq[QW-1]),
        .div_mag (dvs_mag),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = early ? FIX : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(ITER - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: the datapath is a handful of flops, not a memory, so all of it is
    // reset; that also clears the visible results as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            dq          <= '0;
            prem        <= '0;
            dvs_mag     <= '0;
            sign_dvd    <= 1'b0;
            sign_dvs    <= 1'b0;
            dvs_zero    <= 1'b0;
            dvd_lo      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // |dividend| <= 2^(QW-1) always fits QW unsigned bits.
                        dq       <= QW'(dvd_abs);
                        dvs_mag  <= RW'(dvs_abs);
                        prem     <= '0;
                        cnt      <= '0;
                        sign_dvd <= bus.dividend[QW-1];
                        sign_dvs <= bus.divisor[WIDTH-1];
                        dvs_zero <= (bus.divisor == '0);
                        dvd_lo   <= bus.dividend[WIDTH-1:0];
                    end
                end
                CALC: begin
                    dq   <= {dq[QW-2:0], step_q};
                    prem <= step_rem;
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    div_by_zero <= dvs_zero;
                    if (dvs_zero) begin
                        quotient  <= '1;
                        remainder <= dvd_lo;
                    end else begin
                        // Negation wraps mod 2^QW, so -2^(QW-1) / -1 returns 2^(QW-1).
                        quotient  <= (sign_dvd ^ sign_dvs) ? -dq : dq;
                        remainder <= sign_dvd ? WIDTH'(-prem) : WIDTH'(prem);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq -- self-checking bench for div_seq (WIDTH = 6).
// Directed vector table, hand-written sequences for restart/reset corners,
// and a dividend-subset x all-divisor sweep against an integer reference.
// Honours DIV_EARLY_OUT_EN for the expected latency of zero-operand cases.
// -----------------------------------------------------------------------------
module tb_div_seq;

    localparam int W         = 6;
    localparam int QW        = 2 * W;
    localparam int LAT_FULL  = 2 * W + 1;   // posedges after the accepting edge until done is seen
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = LAT_FULL;
`endif
    localparam int NV        = 14;
    localparam int NSW       = 13;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [QW-1:0] dvd;
        logic signed [W-1:0]  dvs;
        logic [QW-1:0]        q;
        logic [W-1:0]         r;
        logic                 z;
    } vec_t;

    vec_t vecs [NV];
    logic signed [QW-1:0] sweep_dvd [NSW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Integer reference: SV / and % truncate toward zero, remainder follows dividend.
    function automatic logic [QW+W:0] ref_div(input logic signed [QW-1:0] a, input logic signed [W-1:0] b);
        int ia;
        int ib;
        int q;
        int r;
        if (b == 0) begin
            return {{QW{1'b1}}, a[W-1:0], 1'b1};
        end
        ia = a;
        ib = b;
        q  = ia / ib;
        r  = ia % ib;
        return {q[QW-1:0], r[W-1:0], 1'b0};
    endfunction

    task automatic launch(input logic signed [QW-1:0] a, input logic signed [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Latency = posedges after the accepting edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic run_op(input logic signed [QW-1:0] a, input logic signed [W-1:0] b, output int lat);
        launch(a, b);
        wait_done(lat);
    endtask

    initial begin
        int   lat;
        int   n_done;
        logic [QW+W:0] exp_v;

        vecs[0]  = '{dvd:  12'sd100,  dvs:  6'sd7,  q: 12'd14,   r: 6'd2,    z: 1'b0};
        vecs[1]  = '{dvd: -12'sd100,  dvs:  6'sd7,  q: 12'd4082, r: 6'h3E,   z: 1'b0};
        vecs[2]  = '{dvd:  12'sd100,  dvs: -6'sd7,  q: 12'd4082, r: 6'd2,    z: 1'b0};
        vecs[3]  = '{dvd: -12'sd100,  dvs: -6'sd7,  q: 12'd14,   r: 6'h3E,   z: 1'b0};
        vecs[4]  = '{dvd:  12'sd5,    dvs:  6'sd0,  q: 12'd4095, r: 6'd5,    z: 1'b1};
        vecs[5]  = '{dvd: -12'sd2048, dvs: -6'sd1,  q: 12'h800,  r: 6'd0,    z: 1'b0};
        vecs[6]  = '{dvd:  12'sd2047, dvs:  6'sd31, q: 12'd66,   r: 6'd1,    z: 1'b0};
        vecs[7]  = '{dvd: -12'sd2048, dvs: -6'sd32, q: 12'd64,   r: 6'd0,    z: 1'b0};
        vecs[8]  = '{dvd: -12'sd2048, dvs:  6'sd31, q: 12'd4030, r: 6'h3E,   z: 1'b0};
        vecs[9]  = '{dvd:  12'sd0,    dvs:  6'sd5,  q: 12'd0,    r: 6'd0,    z: 1'b0};
        vecs[10] = '{dvd:  12'sd0,    dvs:  6'sd0,  q: 12'd4095, r: 6'd0,    z: 1'b1};
        vecs[11] = '{dvd: -12'sd1,    dvs:  6'sd0,  q: 12'd4095, r: 6'h3F,   z: 1'b1};
        vecs[12] = '{dvd:  12'sd3,    dvs: -6'sd32, q: 12'd0,    r: 6'd3,    z: 1'b0};
        vecs[13] = '{dvd: -12'sd37,   dvs:  6'sd6,  q: 12'd4090, r: 6'h3F,   z: 1'b0};

        sweep_dvd = '{-12'sd2048, -12'sd2047, -12'sd1000, -12'sd100, -12'sd37, -12'sd1,
                      12'sd0, 12'sd1, 12'sd5, 12'sd37, 12'sd100, 12'sd1000, 12'sd2047};

        // Reset state.
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",      32'(bus.busy),        32'd0);
        check("rst_done",      32'(bus.done),        32'd0);
        check("rst_quotient",  32'(bus.quotient),    32'd0);
        check("rst_remainder", 32'(bus.remainder),   32'd0);
        check("rst_dbz",       32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, lat);
            check($sformatf("v%0d_latency", i), 32'(lat),
                  32'((vecs[i].dvd == 0 || vecs[i].dvs == 0) ? EARLY_LAT : LAT_FULL));
            check($sformatf("v%0d_quotient", i),  32'(bus.quotient),    32'(vecs[i].q));
            check($sformatf("v%0d_remainder", i), 32'(bus.remainder),   32'(vecs[i].r));
            check($sformatf("v%0d_dbz", i),       32'(bus.div_by_zero), 32'(vecs[i].z));
            check($sformatf("v%0d_busy_at_done", i), 32'(bus.busy),     32'd0);
        end

        // start re-pulsed during CALC is ignored; old result holds while busy.
        launch(-12'sd2048, -6'sd1);
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 1) begin
                check("restart_busy",      32'(bus.busy),     32'd1);
                check("restart_hold_quot", 32'(bus.quotient), 32'(vecs[NV-1].q));
            end
            if (e == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 12'sd7;
                bus.divisor  = 6'sd3;
            end
            if (e == 4) bus.start = 1'b0;
            if (bus.done) begin
                lat = e;
                break;
            end
        end
        check("restart_latency",   32'(lat),             32'(LAT_FULL));
        check("restart_quotient",  32'(bus.quotient),    32'h800);
        check("restart_remainder", 32'(bus.remainder),   32'd0);
        check("restart_dbz",       32'(bus.div_by_zero), 32'd0);

        // start while done is high is ignored too.
        bus.start    = 1'b1;
        bus.dividend = 12'sd100;
        bus.divisor  = 6'sd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("done_start_busy",     32'(bus.busy),     32'd0);
        check("done_start_done",     32'(bus.done),     32'd0);
        check("done_start_quotient", 32'(bus.quotient), 32'h800);
        @(posedge clk);
        @(negedge clk);
        check("done_start_busy2",    32'(bus.busy),     32'd0);

        // Asynchronous reset in the middle of CALC.
        launch(12'sd100, 6'sd7);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_quotient",  32'(bus.quotient),    32'd0);
        check("midrst_remainder", 32'(bus.remainder),   32'd0);
        check("midrst_dbz",       32'(bus.div_by_zero), 32'd0);
        check("midrst_busy",      32'(bus.busy),        32'd0);
        check("midrst_done",      32'(bus.done),        32'd0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done || bus.busy) n_done++;
        end
        check("midrst_discarded", 32'(n_done), 32'd0);
        run_op(12'sd100, 6'sd7, lat);
        check("postrst_latency",   32'(lat),             32'(LAT_FULL));
        check("postrst_quotient",  32'(bus.quotient),    32'd14);
        check("postrst_remainder", 32'(bus.remainder),   32'd2);
        check("postrst_dbz",       32'(bus.div_by_zero), 32'd0);

        // Sweep: dividend subset against all 64 divisors.
        for (int i = 0; i < NSW; i++) begin
            for (int d = -32; d < 32; d++) begin
                logic signed [W-1:0] b;
                b = d[W-1:0];
                exp_v = ref_div(sweep_dvd[i], b);
                run_op(sweep_dvd[i], b, lat);
                check($sformatf("sweep_%0d_by_%0d", sweep_dvd[i], d),
                      32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'(exp_v));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
